// File: rtl/polar_deccoder_pkg.sv
// ---------------------------------------------------------------------------
// polar_deccoder_pkg
// Shared constants for the N=8 successive-cancellation polar decoder.
//   POLAR_SIZE     : default channel LLR width in bits
//   POLAR_N        : code length
//   BELIEF_GUARD   : extra bits carried by internal beliefs so that three
//                    stages of g-node additions never overflow
//   POLAR_BELIEF_W : internal belief width for the default LLR width
//   FROZEN_MASK    : bit i set means u(i+1) is frozen to 0 (bit0 = u1)
// ---------------------------------------------------------------------------
package polar_deccoder_pkg;

  localparam int POLAR_SIZE     = 8;
  localparam int POLAR_N        = 8;
  localparam int BELIEF_GUARD   = 3;
  localparam int POLAR_BELIEF_W = POLAR_SIZE + BELIEF_GUARD;

  // Frozen set {u1,u2,u3,u5}; information set {u4,u6,u7,u8}.
  localparam logic [POLAR_N-1:0] FROZEN_MASK = 8'b0001_0111;

endpackage

// File: rtl/polar_deccoder_if.sv
// ---------------------------------------------------------------------------
// polar_deccoder_if
// Bundles the eight channel LLRs and the eight decoded bits.
//   x1_in..x8_in           : signed LLRs of codeword bits c1..c8 (positive = 0)
//   u1_hat_out..u8_hat_out : decoded message bits u1..u8
// Modports:
//   master : the LLR source / decision sink (drives x, reads u)
//   slave  : the decoder (reads x, drives u)
// Flow control: none. This is a free-running stream -- a new vector is
// taken on every rising clock edge and there is no valid/ready pair and no
// stall; the decisions for the vector sampled at edge k are presented after
// edge k+1.
// ---------------------------------------------------------------------------
interface polar_deccoder_if
  import polar_deccoder_pkg::*;
#(
  parameter int SIZE = POLAR_SIZE
) ();

  logic signed [SIZE-1:0] x1_in, x2_in, x3_in, x4_in;
  logic signed [SIZE-1:0] x5_in, x6_in, x7_in, x8_in;
  logic u1_hat_out, u2_hat_out, u3_hat_out, u4_hat_out;
  logic u5_hat_out, u6_hat_out, u7_hat_out, u8_hat_out;

  modport master (
    output x1_in, x2_in, x3_in, x4_in, x5_in, x6_in, x7_in, x8_in,
    input  u1_hat_out, u2_hat_out, u3_hat_out, u4_hat_out,
           u5_hat_out, u6_hat_out, u7_hat_out, u8_hat_out
  );

  modport slave (
    input  x1_in, x2_in, x3_in, x4_in, x5_in, x6_in, x7_in, x8_in,
    output u1_hat_out, u2_hat_out, u3_hat_out, u4_hat_out,
           u5_hat_out, u6_hat_out, u7_hat_out, u8_hat_out
  );

endinterface

// File: rtl/polar_fg_node.sv
// ---------------------------------------------------------------------------
// polar_fg_node
// One SC tree node: produces both the min-sum f value and the g value for
// the belief pair (a, b).
//   a, b  : input beliefs (signed, W bits)
//   s     : partial sum from the already-decided upper half
//   f_out : sign(a)*sign(b)*min(|a|,|b|)
//   g_out : b + a when s = 0, b - a when s = 1
// Callers size W so that |a|,|b| never reach -2^(W-1), so the magnitude
// negation below cannot wrap.
// ---------------------------------------------------------------------------
module polar_fg_node #(
  parameter int W = 11
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic                s,
  output logic signed [W-1:0] f_out,
  output logic signed [W-1:0] g_out
);

  logic signed [W-1:0] abs_a;
  logic signed [W-1:0] abs_b;
  logic signed [W-1:0] mag;

  assign abs_a = a[W-1] ? -a : a;
  assign abs_b = b[W-1] ? -b : b;
  assign mag   = (abs_a < abs_b) ? abs_a : abs_b;
  assign f_out = (a[W-1] ^ b[W-1]) ? -mag : mag;
  assign g_out = s ? (b - a) : (b + a);

endmodule

// File: rtl/polar_deccoder.sv
// ---------------------------------------------------------------------------
// polar_deccoder
// Successive-cancellation decoder for an N=8 polar code, c = u * F^(x3),
// natural bit order. Two register banks: the LLRs are captured every edge,
// the SC tree evaluates combinationally from that bank, and the eight
// decisions are captured on the following edge (latency 2 edges, one vector
// per cycle).
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; clears both banks, so the
//           outputs drop to 0 immediately and in-flight vectors are lost
//   bus   : slave side of polar_deccoder_if (LLRs in, decisions out)
// ---------------------------------------------------------------------------
module polar_deccoder
  import polar_deccoder_pkg::*;
#(
  parameter int SIZE = POLAR_SIZE
) (
  input  logic             clk,
  input  logic             rst_n,
  polar_deccoder_if.slave  bus
);

  localparam int BW = SIZE + BELIEF_GUARD;
  localparam logic signed [BW-1:0] BELIEF_ZERO = '0;

  // Frozen positions are forced to 0; information bits are 1 only for a
  // strictly negative leaf belief (a zero tie decodes to 0).
  function automatic logic decide(input logic signed [BW-1:0] llr,
                                  input logic [2:0]           idx);
    return !FROZEN_MASK[idx] && (llr < BELIEF_ZERO);
  endfunction

  // -------------------------------------------------------------- input bank
  logic signed [SIZE-1:0] x_d [POLAR_N];
  logic signed [SIZE-1:0] x_q [POLAR_N];

  always_comb begin
    x_d[0] = bus.x1_in;
    x_d[1] = bus.x2_in;
    x_d[2] = bus.x3_in;
    x_d[3] = bus.x4_in;
    x_d[4] = bus.x5_in;
    x_d[5] = bus.x6_in;
    x_d[6] = bus.x7_in;
    x_d[7] = bus.x8_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < POLAR_N; i++) x_q[i] <= '0;
    end else begin
      for (int i = 0; i < POLAR_N; i++) x_q[i] <= x_d[i];
    end
  end

  // ------------------------------------------------------------ SC tree
  logic signed [BW-1:0] l0  [POLAR_N];
  logic signed [BW-1:0] f1  [4];
  logic signed [BW-1:0] g1  [4];
  logic signed [BW-1:0] f2a [2];
  logic signed [BW-1:0] g2a [2];
  logic signed [BW-1:0] f2b [2];
  logic signed [BW-1:0] g2b [2];
  logic signed [BW-1:0] llr1, llr2, llr3, llr4, llr5, llr6, llr7, llr8;
  logic d1, d2, d3, d4, d5, d6, d7, d8;
  logic [3:0] ps_hi;  // u1..u4 re-encoded with F^(x2)
  logic [1:0] ps_a;   // u1..u2 re-encoded with F
  logic [1:0] ps_b;   // u5..u6 re-encoded with F

  // Sign-extend the registered LLRs into the wider belief domain.
  for (genvar i = 0; i < POLAR_N; i++) begin : g_ext
    assign l0[i] = {{(BW-SIZE){x_q[i][SIZE-1]}}, x_q[i]};
  end

  // Stage 1: f feeds the u1..u4 subtree, g (with ps_hi) feeds u5..u8.
  for (genvar i = 0; i < 4; i++) begin : g_s1
    polar_fg_node #(.W(BW)) u_node (
      .a(l0[i]), .b(l0[i+4]), .s(ps_hi[i]), .f_out(f1[i]), .g_out(g1[i])
    );
  end

  // Stage 2 of both halves.
  for (genvar j = 0; j < 2; j++) begin : g_s2
    polar_fg_node #(.W(BW)) u_node_a (
      .a(f1[j]), .b(f1[j+2]), .s(ps_a[j]), .f_out(f2a[j]), .g_out(g2a[j])
    );
    polar_fg_node #(.W(BW)) u_node_b (
      .a(g1[j]), .b(g1[j+2]), .s(ps_b[j]), .f_out(f2b[j]), .g_out(g2b[j])
    );
  end

  // Leaves: each node yields the LLR of an odd bit (f) and the next even
  // bit (g, steered by the odd bit's decision).
  polar_fg_node #(.W(BW)) u_leaf12 (
    .a(f2a[0]), .b(f2a[1]), .s(d1), .f_out(llr1), .g_out(llr2)
  );
  polar_fg_node #(.W(BW)) u_leaf34 (
    .a(g2a[0]), .b(g2a[1]), .s(d3), .f_out(llr3), .g_out(llr4)
  );
  polar_fg_node #(.W(BW)) u_leaf56 (
    .a(f2b[0]), .b(f2b[1]), .s(d5), .f_out(llr5), .g_out(llr6)
  );
  polar_fg_node #(.W(BW)) u_leaf78 (
    .a(g2b[0]), .b(g2b[1]), .s(d7), .f_out(llr7), .g_out(llr8)
  );

  assign d1 = decide(llr1, 3'd0);
  assign d2 = decide(llr2, 3'd1);
  assign d3 = decide(llr3, 3'd2);
  assign d4 = decide(llr4, 3'd3);
  assign d5 = decide(llr5, 3'd4);
  assign d6 = decide(llr6, 3'd5);
  assign d7 = decide(llr7, 3'd6);
  assign d8 = decide(llr8, 3'd7);

  // Partial sums: the decided upper half pushed back through the encoder.
  assign ps_a  = {d2, d1 ^ d2};
  assign ps_b  = {d6, d5 ^ d6};
  assign ps_hi = {d4, d3 ^ d4, d2 ^ d4, d1 ^ d2 ^ d3 ^ d4};

  // ------------------------------------------------------------- output bank
  logic [POLAR_N-1:0] u_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u_q <= '0;
    end else begin
      u_q <= {d8, d7, d6, d5, d4, d3, d2, d1};
    end
  end

  assign bus.u1_hat_out = u_q[0];
  assign bus.u2_hat_out = u_q[1];
  assign bus.u3_hat_out = u_q[2];
  assign bus.u4_hat_out = u_q[3];
  assign bus.u5_hat_out = u_q[4];
  assign bus.u6_hat_out = u_q[5];
  assign bus.u7_hat_out = u_q[6];
  assign bus.u8_hat_out = u_q[7];

endmodule

// File: tb/tb_polar_deccoder.sv
// ---------------------------------------------------------------------------
// tb_polar_deccoder
// Bench for polar_deccoder: directed vectors with hand-derived decisions,
// an asynchronous mid-stream reset, and 1000 random LLR vectors compared
// every cycle against a generic successive-cancellation reference.
// ---------------------------------------------------------------------------
module tb_polar_deccoder;

  localparam int W = 8;
  localparam logic [7:0] TB_FROZEN = 8'b0001_0111;  // u1,u2,u3,u5

  logic clk;
  logic rst_n;

  polar_deccoder_if #(.SIZE(W)) bus ();

  polar_deccoder #(.SIZE(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0] dut_u;
  assign dut_u = {bus.u8_hat_out, bus.u7_hat_out, bus.u6_hat_out, bus.u5_hat_out,
                  bus.u4_hat_out, bus.u3_hat_out, bus.u2_hat_out, bus.u1_hat_out};

  int         n_checks;
  int         n_pass;
  int         cur_vec [8];
  logic [7:0] exp_q [$];
  logic [7:0] exp_cmp;

  int         dir_vec [5][8];
  logic [7:0] dir_exp [5];
  int         zero_vec [8];

  // ---------------------------------------------------------- clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ------------------------------------------------------- reference model
  function automatic int f_ms(input int a, input int b);
    int ma;
    int mb;
    int mag;
    ma  = (a < 0) ? -a : a;
    mb  = (b < 0) ? -b : b;
    mag = (ma < mb) ? ma : mb;
    return ((a < 0) != (b < 0)) ? -mag : mag;
  endfunction

  // Generic SC over the recursive code structure: for every bit, descend
  // the halves of the current block; the lower half needs the decided upper
  // half re-encoded with F^(x log2 half).
  function automatic logic [7:0] sc_model(input int llr [8]);
    logic [7:0] u;
    int cur [8];
    int nxt [8];
    int ps  [8];
    int n;
    int half;
    int base;
    int rel;
    u = '0;
    for (int i = 0; i < 8; i++) begin
      cur  = llr;
      n    = 8;
      base = 0;
      rel  = i;
      while (n > 1) begin
        half = n / 2;
        if (rel < half) begin
          for (int k = 0; k < half; k++) nxt[k] = f_ms(cur[k], cur[k+half]);
        end else begin
          for (int k = 0; k < half; k++) ps[k] = int'(u[base+k]);
          for (int len = 1; len < half; len = len * 2)
            for (int j = 0; j < half; j = j + 2 * len)
              for (int k = 0; k < len; k++) ps[j+k] = ps[j+k] ^ ps[j+k+len];
          for (int k = 0; k < half; k++)
            nxt[k] = (ps[k] != 0) ? (cur[k+half] - cur[k]) : (cur[k+half] + cur[k]);
          base = base + half;
          rel  = rel - half;
        end
        for (int k = 0; k < half; k++) cur[k] = nxt[k];
        n = half;
      end
      u[i] = TB_FROZEN[i] ? 1'b0 : (cur[0] < 0);
    end
    return u;
  endfunction

  // ------------------------------------------------------------ driver tasks
  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got u8..u1=%b, expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic drive_vec(input int v [8]);
    cur_vec    = v;
    bus.x1_in  = W'(v[0]);
    bus.x2_in  = W'(v[1]);
    bus.x3_in  = W'(v[2]);
    bus.x4_in  = W'(v[3]);
    bus.x5_in  = W'(v[4]);
    bus.x6_in  = W'(v[5]);
    bus.x7_in  = W'(v[6]);
    bus.x8_in  = W'(v[7]);
  endtask

  task automatic fill_vec(input int val, output int v [8]);
    for (int k = 0; k < 8; k++) v[k] = val;
  endtask

  // Stream known nonzero decisions, drop reset between edges, then watch
  // the first vector after release come out two edges later.
  task automatic mid_reset();
    int v [8];
    fill_vec(-10, v);
    drive_vec(v);
    @(negedge clk);
    @(negedge clk);
    check8("pre_reset_stream", dut_u, 8'h80);
    #2 rst_n = 1'b0;
    #1 check8("reset_async_clear", dut_u, 8'h00);
    @(negedge clk);
    check8("reset_held_edge1", dut_u, 8'h00);
    @(negedge clk);
    check8("reset_held_edge2", dut_u, 8'h00);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check8("release_edge1", dut_u, 8'h00);
    @(negedge clk);
    check8("release_edge2", dut_u, 8'h80);
  endtask

  // -------------------------------------------------------------- scoreboard
  // Every vector sampled out of reset is expected two edges later.
  always @(posedge clk) begin
    if (rst_n) exp_q.push_back(sc_model(cur_vec));
  end

  always @(negedge rst_n) begin
    exp_q.delete();
  end

  always @(negedge clk) begin
    if (!rst_n) exp_cmp = 8'h00;
    else if (exp_q.size() >= 2) exp_cmp = exp_q.pop_front();
    else exp_cmp = 8'h00;
    check8("stream", dut_u, exp_cmp);
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    int v [8];
    n_checks = 0;
    n_pass   = 0;

    dir_vec[0] = '{1, 1, -1, -1, 1, 1, -1, -1};
    dir_vec[1] = '{10, 10, 10, 10, 10, 10, 10, 10};
    dir_vec[2] = '{-10, -10, -10, -10, -10, -10, -10, -10};
    dir_vec[3] = '{0, 0, 0, 0, 0, 0, 0, 0};
    dir_vec[4] = '{-128, -128, -128, -128, -128, -128, -128, -128};
    dir_exp[0] = 8'b1010_0000;  // u6=1, u8=1
    dir_exp[1] = 8'b0000_0000;
    dir_exp[2] = 8'b1000_0000;  // u8=1
    dir_exp[3] = 8'b0000_0000;  // ties decode to 0
    dir_exp[4] = 8'b1000_0000;  // no wrap at the most negative LLR
    fill_vec(0, zero_vec);

    // Pin the reference model to the hand-derived answers.
    for (int j = 0; j < 5; j++) check8($sformatf("model_dir%0d", j), sc_model(dir_vec[j]), dir_exp[j]);

    rst_n = 1'b0;
    drive_vec(zero_vec);
    #1 check8("reset_state", dut_u, 8'h00);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    // Directed vectors back to back; each appears two edges later.
    for (int j = 0; j < 7; j++) begin
      @(negedge clk);
      if (j >= 2) check8($sformatf("directed%0d", j - 2), dut_u, dir_exp[j-2]);
      if (j < 5) drive_vec(dir_vec[j]);
      else drive_vec(zero_vec);
    end

    // A held vector keeps producing the same decisions.
    drive_vec(dir_vec[0]);
    repeat (4) @(negedge clk);
    check8("held_vector", dut_u, dir_exp[0]);

    // Random stream with occasional extreme LLRs.
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (i == 500) mid_reset();
      for (int k = 0; k < 8; k++) begin
        case ($urandom_range(0, 15))
          0:       v[k] = -128;
          1:       v[k] = 127;
          2:       v[k] = 0;
          default: v[k] = int'($urandom_range(0, 255)) - 128;
        endcase
      end
      drive_vec(v);
    end

    @(negedge clk);
    drive_vec(zero_vec);
    repeat (3) @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
